// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues single-outstanding word reads to instruction memory
// (req/gnt + rvalid), and buffers returned words in a small FIFO so an ID
// stall loses nothing. A redirect flushes the FIFO and discards any response
// still in flight.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_stall             ID cannot accept; head entry held
//   i_redirect(_pc)     load new PC (low 2 bits forced to 0), flush
//   o_imem_req/addr     fetch request and word address (addr == pc)
//   i_imem_gnt          memory accepts the request this cycle
//   i_imem_rvalid/rdata read response
//   o_valid             FIFO head valid
//   o_next_pc, o_data   head entry {fetch address + 4, instruction}; 0 when empty
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_fetch_addr;
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]      r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_target;
    logic             w_empty;
    logic             w_req;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_unused;

    assign w_target = {i_redirect_pc[31:2], 2'b00};
    assign w_unused = ^i_redirect_pc[1:0];
    assign w_empty  = (r_count == '0);

    // Request only with room in the FIFO counted before any same-cycle pop.
    assign w_req   = (r_state == S_RUN) & ~i_redirect & ~i_rst
                   & (r_count < CNT_W'(FIFO_DEPTH));
    assign w_issue = w_req & i_imem_gnt;
    assign w_push  = (r_state == S_WAIT) & i_imem_rvalid & ~i_redirect;
    assign w_pop   = ~w_empty & ~i_stall & ~i_redirect;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_valid     = ~w_empty;
    assign o_next_pc   = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
    assign o_data      = w_empty ? 32'h0 : r_fifo_data[r_rd_ptr];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; S_DROP swallows the one response orphaned by a redirect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_issue) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect) begin
                    w_state_nxt = i_imem_rvalid ? S_RUN : S_DROP;
                end else if (i_imem_rvalid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // PC, fetch address latch and FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_fetch_addr <= 32'h0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            if (i_redirect) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_issue) begin
                r_fetch_addr <= r_pc;
            end

            if (i_redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_fetch_addr + 32'd4;
            r_fifo_data[r_wr_ptr] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: vector table, directed corner sequences and a
// randomized run, all cross-checked every cycle against a queue-based model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0103;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst, stall, redir, gnt, rvalid;
    logic [31:0] rpc, rdata;
    logic        req, valid;
    logic [31:0] addr, npc, data;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redir),
        .i_redirect_pc(rpc), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_valid(valid), .o_next_pc(npc), .o_data(data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered instructions as a queue, plus an
    // "outstanding" token: 0 none, 1 response wanted, 2 response to discard.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_oaddr;
    int          m_out   = 0;
    bit          m_known = 1'b0;

    function automatic logic m_req();
        return !rst && !redir && (m_out == 0) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_check();
        entry_t h;
        if (!m_known) return;
        h = '0;
        if (m_q.size() > 0) h = m_q[0];
        chk("model_req",     32'(req),   32'(m_req()));
        chk("model_addr",    addr,       m_pc);
        chk("model_valid",   32'(valid), 32'(m_q.size() > 0));
        chk("model_next_pc", npc,        h.pc);
        chk("model_data",    data,       h.ins);
    endtask

    task automatic model_step();
        bit     do_pop;
        bit     do_req;
        entry_t e;
        if (rst) begin
            m_pc = RESET_PC & ~32'h3;
            m_q.delete();
            m_out   = 0;
            m_known = 1'b1;
            return;
        end
        if (!m_known) return;
        do_pop = (m_q.size() > 0) && !stall && !redir;
        do_req = m_req();
        if (redir) begin
            if (m_out != 0) m_out = rvalid ? 0 : 2;
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (m_out == 0 && do_req && gnt) begin
                m_oaddr = m_pc;
                m_pc    = m_pc + 32'd4;
                m_out   = 1;
            end else if (m_out == 1 && rvalid) begin
                e.pc  = m_oaddr + 32'd4;
                e.ins = rdata;
                m_q.push_back(e);
                m_out = 0;
            end else if (m_out == 2 && rvalid) begin
                m_out = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] tpc,
                         input logic g, input logic rv, input logic [31:0] d);
        rst = r; stall = s; redir = rd; rpc = tpc; gnt = g; rvalid = rv; rdata = d;
        #1;
    endtask

    task automatic tick();
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_npc;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic s, input logic g, input logic rv, input logic [31:0] d,
                           input logic er, input logic [31:0] ea, input logic ev,
                           input logic [31:0] en, input logic [31:0] ed);
        vec_t v;
        v.stall = s; v.gnt = g; v.rvalid = rv; v.rdata = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_npc = en; v.e_data = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Straight-line fetch from 0x100 with a 10-cycle stall once the first
        // instruction is at the head; rdata = fetch address ^ 0xA5A5_0000.
        add_vec(0, 1, 0, 32'h0,         1, 32'h100, 0, 32'h0,   32'h0);
        add_vec(0, 1, 1, 32'hA5A5_0100, 0, 32'h104, 0, 32'h0,   32'h0);
        add_vec(1, 1, 0, 32'h0,         1, 32'h104, 1, 32'h104, 32'hA5A5_0100);
        add_vec(1, 1, 1, 32'hA5A5_0104, 0, 32'h108, 1, 32'h104, 32'hA5A5_0100);
        for (int i = 0; i < 8; i++)
            add_vec(1, 1, 0, 32'h0,     0, 32'h108, 1, 32'h104, 32'hA5A5_0100);
        add_vec(0, 1, 0, 32'h0,         0, 32'h108, 1, 32'h104, 32'hA5A5_0100);
        add_vec(0, 1, 0, 32'h0,         1, 32'h108, 1, 32'h108, 32'hA5A5_0104);
        add_vec(0, 1, 1, 32'hA5A5_0108, 0, 32'h10C, 0, 32'h0,   32'h0);
        add_vec(0, 1, 0, 32'h0,         1, 32'h10C, 1, 32'h10C, 32'hA5A5_0108);
        add_vec(0, 1, 1, 32'hA5A5_010C, 0, 32'h110, 0, 32'h0,   32'h0);
        add_vec(0, 0, 0, 32'h0,         1, 32'h110, 1, 32'h110, 32'hA5A5_010C);

        // Reset
        drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        tick();
        chk("rst_req2", 32'(req), 32'h0);
        tick();

        foreach (vecs[i]) begin
            drive(0, vecs[i].stall, 0, 32'h0, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            chk($sformatf("vec%0d_req", i),     32'(req),   32'(vecs[i].e_req));
            chk($sformatf("vec%0d_addr", i),    addr,       vecs[i].e_addr);
            chk($sformatf("vec%0d_valid", i),   32'(valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_next_pc", i), npc,        vecs[i].e_npc);
            chk($sformatf("vec%0d_data", i),    data,       vecs[i].e_data);
            tick();
        end

        // Redirect during an outstanding fetch: stale response discarded.
        drive(0, 0, 1, 32'h200, 0, 0, 32'h0);
        chk("rd_req_masked", 32'(req), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("rd_req200", 32'(req), 32'h1);
        chk("rd_addr200", addr, 32'h200);
        tick();
        drive(0, 0, 1, 32'h403, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("drop_req", 32'(req), 32'h0);
        chk("drop_addr", addr, 32'h400);
        chk("drop_valid", 32'(valid), 32'h0);
        tick();
        chk("drop_req2", 32'(req), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("drop_req3", 32'(req), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("post_drop_req", 32'(req), 32'h1);
        chk("post_drop_addr", addr, 32'h400);
        chk("post_drop_valid", 32'(valid), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 1, 32'h1234_5678);
        chk("resp_valid_low", 32'(valid), 32'h0);
        tick();

        // One entry buffered, stalled, then redirect with same-cycle rvalid.
        drive(0, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("first_npc", npc, 32'h404);
        chk("first_data", data, 32'h1234_5678);
        chk("first_valid", 32'(valid), 32'h1);
        tick();
        drive(0, 1, 1, 32'h800, 0, 1, 32'hBAD0_BAD0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_npc", npc, 32'h0);
        chk("flush_data", data, 32'h0);
        chk("flush_req", 32'(req), 32'h1);
        chk("flush_addr", addr, 32'h800);
        tick();

        // PC wrap, then reset while a response is outstanding.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("wrap_addr", addr, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 32'h0, 0, 1, 32'hC0FF_EE00);
        chk("wrap_pc", addr, 32'h0);
        tick();
        drive(0, 1, 0, 32'h0, 1, 0, 32'h0);
        chk("wrap_npc", npc, 32'h0);
        chk("wrap_data", data, 32'hC0FF_EE00);
        chk("wrap_valid", 32'(valid), 32'h1);
        chk("wrap_req", 32'(req), 32'h1);
        tick();
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("rst_wait_req", 32'(req), 32'h0);
        tick();
        drive(0, 0, 0, 32'h0, 0, 1, 32'hBADB_AD00);
        chk("rst_wait_valid", 32'(valid), 32'h0);
        chk("rst_wait_addr", addr, 32'h100);
        tick();

        // Slow grant: request and address held until gnt.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
            chk($sformatf("slow_req%0d", i), 32'(req), 32'h1);
            chk($sformatf("slow_addr%0d", i), addr, 32'h100);
            chk($sformatf("slow_valid%0d", i), 32'(valid), 32'h0);
            tick();
        end
        drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
        chk("slow_gnt_addr", addr, 32'h100);
        tick();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
        chk("slow_inc_addr", addr, 32'h104);
        chk("slow_inc_req", 32'(req), 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, rd, g, rv;
            logic [31:0] t;
            r  = ($urandom_range(99) < 2);
            s  = ($urandom_range(99) < 30);
            rd = ($urandom_range(99) < 8);
            g  = ($urandom_range(99) < 70);
            rv = ($urandom_range(99) < 45);
            t  = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : 32'($urandom());
            drive(r, s, rd, t, g, rv, 32'($urandom()));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
